// File: rtl/scrn_pkg.sv
// ---------------------------------------------------------------------------
// scrn_pkg
// Shared definitions for the screen-timing generator and receiver:
//   rx_state_t     receiver lock state
//   timing_meas_t  one measured timing set at the default counter width
//   *_TOT / *_ACT  totals and active sizes of the standard formats
// ---------------------------------------------------------------------------
package scrn_pkg;

    localparam int SCRN_WIDTH = 12;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [SCRN_WIDTH-1:0] h_tot;
        logic [SCRN_WIDTH-1:0] h_act;
        logic [SCRN_WIDTH-1:0] v_tot;
        logic [SCRN_WIDTH-1:0] v_act;
    } timing_meas_t;

    // 640x480
    localparam int H_TOT_480P  = 800;
    localparam int H_ACT_480P  = 640;
    localparam int V_TOT_480P  = 525;
    localparam int V_ACT_480P  = 480;

    // 1280x720
    localparam int H_TOT_720P  = 1650;
    localparam int H_ACT_720P  = 1280;
    localparam int V_TOT_720P  = 750;
    localparam int V_ACT_720P  = 720;

    // 1920x1080
    localparam int H_TOT_1080P = 2200;
    localparam int H_ACT_1080P = 1920;
    localparam int V_TOT_1080P = 1125;
    localparam int V_ACT_1080P = 1080;

endpackage

// File: rtl/scrn_timing_rx_edge.sv
// ---------------------------------------------------------------------------
// scrn_edge_det
// One-bit registered edge detector. The input is sampled once (cur) and
// once more (prev); rise/fall are decoded from those two registers.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   d            input level
//   cur, prev    first and second registered samples
//   rise, fall   prev/cur = 0/1 and 1/0 respectively
// ---------------------------------------------------------------------------
module scrn_edge_det
    import scrn_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic cur,
    output logic prev,
    output logic rise,
    output logic fall
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= 1'b0;
            prev <= 1'b0;
        end else begin
            cur  <= d;
            prev <= cur;
        end
    end

    assign rise = cur & ~prev;
    assign fall = ~cur & prev;

endmodule

// File: rtl/scrn_timing_rx.sv
// ---------------------------------------------------------------------------
// scrn_timing_rx
// Video timing receiver: recovers active-pixel coordinates from an
// hsync/vsync/de stream, measures line/frame sizes and declares lock once
// two consecutive clean frames measure identically.
// Optional feature macro: SCRN_RX_ERR_CNT_EN adds err_cnt, a saturating
// count of LOCKED->MEASURE transitions.
// Ports:
//   clk_pix, rst_pix_n         pixel clock, asynchronous active-low reset
//   hsync, vsync, de           incoming timing (active high)
//   sx, sy, de_o               position and aligned data enable (2 clk late)
//   frame_start                one-cycle pulse per vsync rising edge
//   h_tot, h_act, v_tot, v_act stored measurement set
//   err_cnt                    lock-loss count (macro only)
//   locked                     format stable
// ---------------------------------------------------------------------------
module scrn_timing_rx
    import scrn_pkg::*;
#(
    parameter int WIDTH = SCRN_WIDTH
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic [WIDTH-1:0] sx,
    output logic [WIDTH-1:0] sy,
    output logic             de_o,
    output logic             frame_start,
    output logic [WIDTH-1:0] h_tot,
    output logic [WIDTH-1:0] h_act,
    output logic [WIDTH-1:0] v_tot,
    output logic [WIDTH-1:0] v_act,
`ifdef SCRN_RX_ERR_CNT_EN
    output logic [WIDTH-1:0] err_cnt,
`endif
    output logic             locked
);

    // Same layout as timing_meas_t, but sized by this instance's WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] h_tot;
        logic [WIDTH-1:0] h_act;
        logic [WIDTH-1:0] v_tot;
        logic [WIDTH-1:0] v_act;
    } meas_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    logic hs_cur, hs_prev, hs_rise, hs_fall;
    logic vs_cur, vs_prev, vs_rise, vs_fall;
    logic de_cur, de_prev, de_rise, de_fall;
    logic unused_edges;

    rx_state_t        state, state_n;
    logic [WIDTH-1:0] hc, lc, vc;
    logic [WIDTH-1:0] first_len, first_la;
    logic             len_seen, la_seen, frame_bad;
    meas_t            meas;
    logic             stored_valid;

    logic [WIDTH-1:0] line_len_n, la_n, vc_n, lc_n;
    logic [WIDTH-1:0] first_len_n, first_la_n;
    logic             bad_n, timeout, store;
    meas_t            cand;

    scrn_edge_det u_hs (.clk(clk_pix), .rst_n(rst_pix_n), .d(hsync),
                        .cur(hs_cur), .prev(hs_prev), .rise(hs_rise), .fall(hs_fall));
    scrn_edge_det u_vs (.clk(clk_pix), .rst_n(rst_pix_n), .d(vsync),
                        .cur(vs_cur), .prev(vs_prev), .rise(vs_rise), .fall(vs_fall));
    scrn_edge_det u_de (.clk(clk_pix), .rst_n(rst_pix_n), .d(de),
                        .cur(de_cur), .prev(de_prev), .rise(de_rise), .fall(de_fall));

    assign unused_edges = ^{hs_cur, hs_prev, hs_fall, vs_cur, vs_prev, vs_fall, de_rise};

    // Line and frame bookkeeping as it would stand after this cycle's edges.
    // The hsync line update and a de falling edge are folded in before the
    // frame candidate is built, so edges coinciding with vsync count toward
    // the frame that is ending.
    always_comb begin
        line_len_n  = sat_inc(hc);
        la_n        = sat_inc(sx);
        vc_n        = hs_rise ? sat_inc(vc) : vc;
        lc_n        = de_fall ? sat_inc(lc) : lc;
        first_len_n = (hs_rise && !len_seen) ? line_len_n : first_len;
        first_la_n  = (de_fall && !la_seen)  ? la_n       : first_la;
        bad_n       = frame_bad
                    | (hs_rise && len_seen && (line_len_n != first_len))
                    | (de_fall && la_seen  && (la_n != first_la));
        cand.h_tot  = first_len_n;
        cand.h_act  = first_la_n;
        cand.v_tot  = vc_n;
        cand.v_act  = lc_n;
        timeout     = (hc == '1) && !hs_rise;
    end

    // Lock state register.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state <= SEARCH;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode. A stored set taken from a bad frame, or carried over
    // from before a SEARCH, is not valid, so a match against it cannot lock.
    always_comb begin
        state_n = state;
        store   = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_rise) begin
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                if (vs_rise) begin
                    if (!bad_n && stored_valid && (cand == meas)) begin
                        state_n = LOCKED;
                    end else begin
                        store = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (vs_rise && (bad_n || (cand != meas))) begin
                    store   = 1'b1;
                    state_n = MEASURE;
                end
            end
            default: begin
                state_n = SEARCH;
            end
        endcase
        if (timeout) begin
            state_n = SEARCH;
            store   = 1'b0;
        end
    end

    // Counters, per-frame capture and the stored measurement set.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            hc           <= '0;
            sx           <= '0;
            lc           <= '0;
            vc           <= '0;
            first_len    <= '0;
            first_la     <= '0;
            len_seen     <= 1'b0;
            la_seen      <= 1'b0;
            frame_bad    <= 1'b0;
            frame_start  <= 1'b0;
            meas         <= '0;
            stored_valid <= 1'b0;
        end else begin
            hc          <= hs_rise ? '0 : sat_inc(hc);
            frame_start <= vs_rise;
            if (de_cur) begin
                sx <= de_prev ? sat_inc(sx) : '0;
            end
            if (vs_rise) begin
                vc        <= '0;
                lc        <= '0;
                frame_bad <= 1'b0;
                len_seen  <= 1'b0;
                la_seen   <= 1'b0;
            end else begin
                vc        <= vc_n;
                lc        <= lc_n;
                frame_bad <= bad_n;
                first_len <= first_len_n;
                first_la  <= first_la_n;
                len_seen  <= len_seen | hs_rise;
                la_seen   <= la_seen | de_fall;
            end
            if (store) begin
                meas <= cand;
            end
            if (state_n == SEARCH) begin
                stored_valid <= 1'b0;
            end else if (store) begin
                stored_valid <= !bad_n;
            end
        end
    end

`ifdef SCRN_RX_ERR_CNT_EN
    // Lock-loss counter; only reset clears it.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            err_cnt <= '0;
        end else if ((state == LOCKED) && (state_n == MEASURE)) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end
`endif

    assign sy     = lc;
    assign de_o   = de_prev;
    assign h_tot  = meas.h_tot;
    assign h_act  = meas.h_act;
    assign v_tot  = meas.v_tot;
    assign v_act  = meas.v_act;
    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_scrn_timing_rx.sv
// ---------------------------------------------------------------------------
// tb_scrn_timing_rx
// Directed bench for scrn_timing_rx using small synthetic formats so that
// whole frames fit in a short run. Format A: 20x12 total, 12x8 active.
// Format B: 16x10 total, 10x6 active. Active pixels sit at the end of each
// line and frame, so de falls together with the next hsync (and with vsync
// on the last active line).
// ---------------------------------------------------------------------------
module tb_scrn_timing_rx;

    localparam int W = 12;

    logic         clk_pix = 1'b0;
    logic         rst_pix_n;
    logic         hsync, vsync, de;
    logic [W-1:0] sx, sy, h_tot, h_act, v_tot, v_act;
    logic         de_o, frame_start, locked;
`ifdef SCRN_RX_ERR_CNT_EN
    logic [W-1:0] err_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    int fmt_ht, fmt_ha, fmt_vt, fmt_va, fmt_hs, fmt_vs;

    logic         obs_fs_pre, obs_fs, obs_fs_post, obs_lock_pre, obs_lock;
    logic [W-1:0] obs_ht, obs_ha, obs_vt, obs_va, obs_err;

    scrn_timing_rx #(.WIDTH(W)) dut (
        .clk_pix     (clk_pix),
        .rst_pix_n   (rst_pix_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .sx          (sx),
        .sy          (sy),
        .de_o        (de_o),
        .frame_start (frame_start),
        .h_tot       (h_tot),
        .h_act       (h_act),
        .v_tot       (v_tot),
        .v_act       (v_act),
`ifdef SCRN_RX_ERR_CNT_EN
        .err_cnt     (err_cnt),
`endif
        .locked      (locked)
    );

    always #5 clk_pix = ~clk_pix;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_format(input int ht, input int ha, input int vt,
                              input int va, input int hs, input int vs);
        fmt_ht = ht; fmt_ha = ha; fmt_vt = vt;
        fmt_va = va; fmt_hs = hs; fmt_vs = vs;
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk_pix);
            hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        end
    endtask

    // Drives one frame; row long_row (if >= 0) gets one extra blank clock.
    // Samples outputs around the frame-start pulse: index 2 shows the
    // response to the vsync pixel (index 0).
    task automatic send_frame(input int long_row);
        int idx;
        int len;
        idx = 0;
        for (int y = 0; y < fmt_vt; y++) begin
            len = (y == long_row) ? fmt_ht + 1 : fmt_ht;
            for (int x = 0; x < len; x++) begin
                @(negedge clk_pix);
                if (idx == 1) begin
                    obs_fs_pre   = frame_start;
                    obs_lock_pre = locked;
                end
                if (idx == 2) begin
                    obs_fs   = frame_start;
                    obs_lock = locked;
                    obs_ht   = h_tot;
                    obs_ha   = h_act;
                    obs_vt   = v_tot;
                    obs_va   = v_act;
`ifdef SCRN_RX_ERR_CNT_EN
                    obs_err  = err_cnt;
`else
                    obs_err  = '0;
`endif
                end
                if (idx == 3) begin
                    obs_fs_post = frame_start;
                end
                hsync = (x < fmt_hs);
                vsync = (y < fmt_vs);
                de    = (x >= fmt_ht - fmt_ha) && (x < fmt_ht) && (y >= fmt_vt - fmt_va);
                idx++;
            end
        end
    endtask

    task automatic test_reset;
        rst_pix_n = 1'b0;
        hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        repeat (3) @(negedge clk_pix);
        vectors++;
        if ({sx, sy} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_pos: got sx=%0d sy=%0d, want 0 0", sx, sy);
        end
        vectors++;
        if ({de_o, frame_start, locked} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b, want 000", {de_o, frame_start, locked});
        end
        vectors++;
        if ({h_tot, h_act, v_tot, v_act} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_meas: got %0d/%0d/%0d/%0d, want 0/0/0/0",
                     h_tot, h_act, v_tot, v_act);
        end
        rst_pix_n = 1'b1;
        drive_idle(5);
    endtask

    task automatic test_lock_acquire;
        set_format(20, 12, 12, 8, 3, 2);
        send_frame(-1);
        vectors++;
        if (obs_fs !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fs_first_edge: got %b, want 1", obs_fs);
        end
        vectors++;
        if (obs_lock !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lock_edge1: got %b, want 0", obs_lock);
        end
        vectors++;
        if (obs_ht !== 12'd0) begin
            miscompares++;
            $display("[TB] FAIL search_no_store: got h_tot=%0d, want 0", obs_ht);
        end
        send_frame(-1);
        vectors++;
        if (obs_lock !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lock_edge2: got %b, want 0", obs_lock);
        end
        vectors++;
        if ({obs_ht, obs_ha, obs_vt, obs_va} !== {12'd20, 12'd12, 12'd12, 12'd8}) begin
            miscompares++;
            $display("[TB] FAIL meas_A_edge2: got %0d/%0d/%0d/%0d, want 20/12/12/8",
                     obs_ht, obs_ha, obs_vt, obs_va);
        end
        send_frame(-1);
        vectors++;
        if ({obs_lock_pre, obs_lock} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL lock_edge3: got pre/post=%b, want 01", {obs_lock_pre, obs_lock});
        end
        vectors++;
        if ({obs_fs_pre, obs_fs, obs_fs_post} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL fs_pulse_width: got %b, want 010", {obs_fs_pre, obs_fs, obs_fs_post});
        end
        vectors++;
        if ({obs_ht, obs_ha, obs_vt, obs_va} !== {12'd20, 12'd12, 12'd12, 12'd8}) begin
            miscompares++;
            $display("[TB] FAIL meas_A_locked: got %0d/%0d/%0d/%0d, want 20/12/12/8",
                     obs_ht, obs_ha, obs_vt, obs_va);
        end
    endtask

    // One locked frame with a 2-deep expected-value pipeline for sx/sy/de_o.
    task automatic test_position;
        int idx;
        logic d, pd1, pd2;
        int   csx, csy, psx1, psx2, psy1, psy2;
        idx = 0;
        pd1 = 1'b0; pd2 = 1'b0;
        psx1 = 0; psx2 = 0; psy1 = 0; psy2 = 0;
        for (int y = 0; y < fmt_vt; y++) begin
            for (int x = 0; x < fmt_ht; x++) begin
                @(negedge clk_pix);
                if (idx == 2) begin
                    vectors++;
                    if (locked !== 1'b1) begin
                        miscompares++;
                        $display("[TB] FAIL pos_frame_locked: got %b, want 1", locked);
                    end
                end
                if (idx >= 2) begin
                    vectors++;
                    if (de_o !== pd2) begin
                        miscompares++;
                        $display("[TB] FAIL de_o_align idx=%0d: got %b, want %b", idx, de_o, pd2);
                    end
                    if (pd2) begin
                        vectors++;
                        if ({sx, sy} !== {W'(psx2), W'(psy2)}) begin
                            miscompares++;
                            $display("[TB] FAIL pos idx=%0d: got sx=%0d sy=%0d, want sx=%0d sy=%0d",
                                     idx, sx, sy, psx2, psy2);
                        end
                    end
                end
                d     = (x >= fmt_ht - fmt_ha) && (y >= fmt_vt - fmt_va);
                hsync = (x < fmt_hs);
                vsync = (y < fmt_vs);
                de    = d;
                csx   = x - (fmt_ht - fmt_ha);
                csy   = y - (fmt_vt - fmt_va);
                pd2 = pd1;  psx2 = psx1; psy2 = psy1;
                pd1 = d;    psx1 = csx;  psy1 = csy;
                idx++;
            end
        end
    endtask

    task automatic test_bad_line;
        send_frame(5);
        vectors++;
        if (obs_lock !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bad_frame_start_locked: got %b, want 1", obs_lock);
        end
        send_frame(-1);
        vectors++;
        if ({obs_lock_pre, obs_lock} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL bad_frame_drop: got pre/post=%b, want 10", {obs_lock_pre, obs_lock});
        end
`ifdef SCRN_RX_ERR_CNT_EN
        vectors++;
        if (obs_err !== 12'd1) begin
            miscompares++;
            $display("[TB] FAIL err_cnt_bad_line: got %0d, want 1", obs_err);
        end
`endif
        send_frame(-1);
        vectors++;
        if (obs_lock !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bad_frame_no_early_relock: got %b, want 0", obs_lock);
        end
        send_frame(-1);
        vectors++;
        if (obs_lock !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bad_frame_relock: got %b, want 1", obs_lock);
        end
    endtask

    task automatic test_format_switch;
        set_format(16, 10, 10, 6, 2, 2);
        send_frame(-1);
        vectors++;
        if (obs_lock !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL switch_last_A_frame: got %b, want 1", obs_lock);
        end
        send_frame(-1);
        vectors++;
        if (obs_lock !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL switch_drop: got %b, want 0", obs_lock);
        end
        vectors++;
        if ({obs_ht, obs_ha, obs_vt, obs_va} !== {12'd16, 12'd10, 12'd10, 12'd6}) begin
            miscompares++;
            $display("[TB] FAIL meas_B_stored: got %0d/%0d/%0d/%0d, want 16/10/10/6",
                     obs_ht, obs_ha, obs_vt, obs_va);
        end
`ifdef SCRN_RX_ERR_CNT_EN
        vectors++;
        if (obs_err !== 12'd2) begin
            miscompares++;
            $display("[TB] FAIL err_cnt_switch: got %0d, want 2", obs_err);
        end
`endif
        send_frame(-1);
        vectors++;
        if (obs_lock !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL switch_relock: got %b, want 1", obs_lock);
        end
        vectors++;
        if ({obs_ht, obs_ha, obs_vt, obs_va} !== {12'd16, 12'd10, 12'd10, 12'd6}) begin
            miscompares++;
            $display("[TB] FAIL meas_B_locked: got %0d/%0d/%0d/%0d, want 16/10/10/6",
                     obs_ht, obs_ha, obs_vt, obs_va);
        end
    endtask

    task automatic test_timeout;
        drive_idle(2000);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_not_yet: got %b, want 1", locked);
        end
        drive_idle(2200);
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_search: got %b, want 0", locked);
        end
        send_frame(-1);
        send_frame(-1);
        vectors++;
        if (obs_lock !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_edge2: got %b, want 0", obs_lock);
        end
        send_frame(-1);
        vectors++;
        if (obs_lock !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_relock_edge3: got %b, want 1", obs_lock);
        end
    endtask

    task automatic test_reset_midline;
        int x;
        int y;
        for (int i = 0; i < 5 * fmt_ht + 13; i++) begin
            x = i % fmt_ht;
            y = i / fmt_ht;
            @(negedge clk_pix);
            hsync = (x < fmt_hs);
            vsync = (y < fmt_vs);
            de    = (x >= fmt_ht - fmt_ha) && (y >= fmt_vt - fmt_va);
        end
        vectors++;
        if ({locked, de_o} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_state: got locked/de_o=%b, want 11", {locked, de_o});
        end
        #2;
        rst_pix_n = 1'b0;
        #1;
        vectors++;
        if ({sx, sy, h_tot, h_act, v_tot, v_act} !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_values: got sx=%0d sy=%0d meas=%0d/%0d/%0d/%0d, want all 0",
                     sx, sy, h_tot, h_act, v_tot, v_act);
        end
        vectors++;
        if ({de_o, frame_start, locked} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL async_reset_flags: got %b, want 000", {de_o, frame_start, locked});
        end
`ifdef SCRN_RX_ERR_CNT_EN
        vectors++;
        if (err_cnt !== 12'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_err_cnt: got %0d, want 0", err_cnt);
        end
`endif
        @(negedge clk_pix);
        rst_pix_n = 1'b1;
        drive_idle(10);
        send_frame(-1);
        vectors++;
        if ({obs_lock, obs_ht} !== {1'b0, 12'd0}) begin
            miscompares++;
            $display("[TB] FAIL rst_edge1: got locked=%b h_tot=%0d, want 0 0", obs_lock, obs_ht);
        end
        send_frame(-1);
        vectors++;
        if (obs_lock !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_edge2: got %b, want 0", obs_lock);
        end
        send_frame(-1);
        vectors++;
        if (obs_lock !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_relock_edge3: got %b, want 1", obs_lock);
        end
    endtask

    initial begin
        $display("[TB] scrn_timing_rx directed run");
        test_reset;
        test_lock_acquire;
        test_position;
        test_bad_line;
        test_format_switch;
        test_timeout;
        test_reset_midline;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
